// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared size encodings, FSM state type and limits for data_mem_hs
package dmem_pkg;

    localparam logic [1:0] SZ_WORD    = 2'b00;
    localparam logic [1:0] SZ_BYTE    = 2'b01;
    localparam logic [1:0] SZ_HALF    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    localparam int LATENCY_MAX = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic [2:0] size_nbytes(input logic [1:0] size);
        case (size)
            SZ_WORD: size_nbytes = 3'd4;
            SZ_HALF: size_nbytes = 3'd2;
            default: size_nbytes = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - right-justifies and zero/sign-extends big-endian load bytes
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] raw_bytes,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] data
);

    // raw_bytes[31:24] is the byte at the request address
    always_comb begin
        data = raw_bytes;
        case (size)
            SZ_BYTE: data = {{24{is_signed & raw_bytes[31]}}, raw_bytes[31:24]};
            SZ_HALF: data = {{16{is_signed & raw_bytes[31]}}, raw_bytes[31:16]};
            default: data = raw_bytes;
        endcase
    end

endmodule

// File: rtl/data_mem_hs.sv
// rtl/data_mem_hs.sv - handshaked byte-addressed data memory; DATA_MEM_HS_ALIGN_CHECK_EN enables alignment errors
module data_mem_hs
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 256,
    parameter int ADDR_W      = 32,
    parameter int LATENCY     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int EW = ((ADDR_W > 17) ? ADDR_W : 17) + 1;

    if (LATENCY < 1 || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("data_mem_hs: LATENCY must be within 1..15");
    end
    if (DEPTH_BYTES < 16 || DEPTH_BYTES > 65536 ||
        (DEPTH_BYTES & (DEPTH_BYTES - 1)) != 0) begin : g_bad_depth
        $error("data_mem_hs: DEPTH_BYTES must be a power of two within 16..65536");
    end
    if (ADDR_W < AW) begin : g_bad_addr_w
        $error("data_mem_hs: ADDR_W too narrow for DEPTH_BYTES");
    end

    state_t             state, state_n;
    logic [3:0]         cnt, cnt_n;
    logic               access;

    logic               lat_rw;
    logic [1:0]         lat_size;
    logic               lat_signed;
    logic [ADDR_W-1:0]  lat_addr;
    logic [31:0]        lat_wdata;

    logic [7:0]         mem [DEPTH_BYTES];
    logic [AW-1:0]      idx0, idx1, idx2, idx3;
    logic [EW-1:0]      end_addr;
    logic               out_of_range, misaligned, req_err, mem_we;
    logic [31:0]        raw_bytes, load_data;

    assign req_ready = (state == ST_IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        access  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_n = ST_WAIT;
                    cnt_n   = 4'(LATENCY);
                end
            end
            ST_WAIT: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_n = ST_RESP;
                    access  = 1'b1;
                end
            end
            ST_RESP: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Range check is done one bit wider than the address so the top of the space cannot wrap.
    assign end_addr     = EW'(lat_addr) + EW'(size_nbytes(lat_size)) - EW'(1);
    assign out_of_range = (end_addr >= EW'(DEPTH_BYTES));

`ifdef DATA_MEM_HS_ALIGN_CHECK_EN
    assign misaligned = ((lat_size == SZ_HALF) && lat_addr[0]) ||
                        ((lat_size == SZ_WORD) && (lat_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign req_err = (lat_size == SZ_ILLEGAL) || out_of_range || misaligned;
    assign mem_we  = access && !reset && !req_err && !lat_rw;

    assign idx0 = lat_addr[AW-1:0];
    assign idx1 = idx0 + AW'(1);
    assign idx2 = idx0 + AW'(2);
    assign idx3 = idx0 + AW'(3);

    assign raw_bytes = {mem[idx0], mem[idx1], mem[idx2], mem[idx3]};

    dmem_lane_align u_lane_align (
        .raw_bytes (raw_bytes),
        .size      (lat_size),
        .is_signed (lat_signed),
        .data      (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'd0;
            rsp_err    <= 1'b0;
            lat_rw     <= 1'b0;
            lat_size   <= SZ_WORD;
            lat_signed <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= 32'd0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rsp_valid <= access;
            if (state == ST_IDLE && req_valid) begin
                lat_rw     <= req_rw;
                lat_size   <= req_size;
                lat_signed <= req_signed;
                lat_addr   <= req_addr;
                lat_wdata  <= req_wdata;
            end
            if (access) begin
                rsp_err   <= req_err;
                rsp_rdata <= (req_err || !lat_rw) ? 32'd0 : load_data;
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            case (lat_size)
                SZ_WORD: begin
                    mem[idx0] <= lat_wdata[31:24];
                    mem[idx1] <= lat_wdata[23:16];
                    mem[idx2] <= lat_wdata[15:8];
                    mem[idx3] <= lat_wdata[7:0];
                end
                SZ_HALF: begin
                    mem[idx0] <= lat_wdata[15:8];
                    mem[idx1] <= lat_wdata[7:0];
                end
                default: mem[idx0] <= lat_wdata[7:0];
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_hs.sv
// tb/tb_data_mem_hs.sv - self-checking bench for data_mem_hs (vectors, corner sequences, random vs model)
module tb_data_mem_hs;

    localparam int DEPTH = 256;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_rw;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] mdl [DEPTH];

    typedef struct {
        logic        rw;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mask;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl [$];

    data_mem_hs #(.DEPTH_BYTES(DEPTH), .ADDR_W(32), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rw     (req_rw),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic rw, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] mask, input logic [31:0] rd, input logic er);
        vec_t v;
        v.rw = rw; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.mask = mask; v.exp_rdata = rd; v.exp_err = er;
        return v;
    endfunction

    // Reference: memory as a byte array, access as a list of consecutive big-endian bytes.
    task automatic model_access(input logic rw, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rd, output logic er);
        int nb;
        longint val;
        nb = (size == 2'b00) ? 4 : (size == 2'b10) ? 2 : 1;
        er = (size == 2'b11) || (longint'(addr) + nb > DEPTH);
`ifdef DATA_MEM_HS_ALIGN_CHECK_EN
        if (size == 2'b00 && addr % 4 != 0) er = 1'b1;
        if (size == 2'b10 && addr % 2 != 0) er = 1'b1;
`endif
        rd = 32'd0;
        if (!er) begin
            if (rw) begin
                val = 0;
                for (int i = 0; i < nb; i++) val = val * 256 + mdl[int'(addr) + i];
                if (sgn && nb < 4 && val >= (longint'(1) << (8 * nb - 1)))
                    val = val - (longint'(1) << (8 * nb));
                rd = val[31:0];
            end else begin
                for (int i = 0; i < nb; i++)
                    mdl[int'(addr) + i] = 8'(wdata >> (8 * (nb - 1 - i)));
            end
        end
    endtask

    task automatic run_req(input logic rw, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        req_valid = 1'b1; req_rw = rw; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_rw = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!rsp_valid && lat < 20);
        rd = rsp_rdata;
        er = rsp_err;
        if (!rsp_valid) lat = -1;
        @(posedge clk); #1;
        check("strobe_one_cycle", {31'd0, rsp_valid}, 32'd0);
        check("rdata_hold", rsp_rdata, rd);
        check("err_hold", {31'd0, rsp_err}, {31'd0, er});
        check("ready_after_resp", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic do_model_req(input string name, input logic rw, input logic [1:0] size,
                                input logic sgn, input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] erd, rd;
        logic        eer, er;
        int          lat;
        model_access(rw, size, sgn, addr, wdata, erd, eer);
        run_req(rw, size, sgn, addr, wdata, rd, er, lat);
        check({name, "_lat"}, lat, LAT);
        check({name, "_rdata"}, rd, erd);
        check({name, "_err"}, {31'd0, er}, {31'd0, eer});
    endtask

    initial begin
        logic [31:0] rd, erd, addr;
        logic        er, eer, seen;
        int          lat, r;

        reset = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        @(posedge clk); @(posedge clk); #1;
        check("reset_ready", {31'd0, req_ready}, 32'd1);
        check("reset_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rdata", rsp_rdata, 32'd0);
        check("reset_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk); reset = 1'b0;

        for (int a = 0; a < DEPTH; a += 4) do_model_req("init", 1'b0, 2'b00, 1'b0, a, $urandom);

        tbl.push_back(mk(0, 2'b00, 0, 32'h10, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h0, 0));
        tbl.push_back(mk(1, 2'b00, 0, 32'h10, 32'h0, 32'hFFFFFFFF, 32'hDEADBEEF, 0));
        tbl.push_back(mk(1, 2'b01, 0, 32'h10, 32'h0, 32'hFFFFFFFF, 32'h000000DE, 0));
        tbl.push_back(mk(1, 2'b01, 1, 32'h13, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFEF, 0));
        tbl.push_back(mk(1, 2'b10, 1, 32'h12, 32'h0, 32'hFFFFFFFF, 32'hFFFFBEEF, 0));
        tbl.push_back(mk(1, 2'b10, 0, 32'h12, 32'h0, 32'hFFFFFFFF, 32'h0000BEEF, 0));
        tbl.push_back(mk(1, 2'b01, 1, 32'h10, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFDE, 0));
        tbl.push_back(mk(1, 2'b10, 1, 32'h10, 32'h0, 32'hFFFFFFFF, 32'hFFFFDEAD, 0));
        tbl.push_back(mk(0, 2'b10, 0, 32'h20, 32'h00001234, 32'hFFFFFFFF, 32'h0, 0));
        tbl.push_back(mk(1, 2'b00, 0, 32'h20, 32'h0, 32'hFFFF0000, 32'h12340000, 0));
        tbl.push_back(mk(0, 2'b01, 0, 32'hFE, 32'h000000A5, 32'hFFFFFFFF, 32'h0, 0));
        tbl.push_back(mk(0, 2'b01, 0, 32'hFF, 32'h0000005A, 32'hFFFFFFFF, 32'h0, 0));
        tbl.push_back(mk(0, 2'b00, 0, 32'hFE, 32'h11223344, 32'hFFFFFFFF, 32'h0, 1));
        tbl.push_back(mk(1, 2'b10, 0, 32'hFE, 32'h0, 32'hFFFFFFFF, 32'h0000A55A, 0));
        tbl.push_back(mk(1, 2'b10, 0, 32'hFF, 32'h0, 32'hFFFFFFFF, 32'h0, 1));
        tbl.push_back(mk(1, 2'b01, 1, 32'hFF, 32'h0, 32'hFFFFFFFF, 32'h0000005A, 0));
        tbl.push_back(mk(1, 2'b11, 0, 32'h00, 32'h0, 32'hFFFFFFFF, 32'h0, 1));
        tbl.push_back(mk(0, 2'b11, 0, 32'h04, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1));
        tbl.push_back(mk(1, 2'b00, 0, 32'hFFFFFFFC, 32'h0, 32'hFFFFFFFF, 32'h0, 1));
        tbl.push_back(mk(0, 2'b00, 1, 32'h30, 32'h80000001, 32'hFFFFFFFF, 32'h0, 0));
        tbl.push_back(mk(1, 2'b00, 1, 32'h30, 32'h0, 32'hFFFFFFFF, 32'h80000001, 0));

        foreach (tbl[i]) begin
            model_access(tbl[i].rw, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, erd, eer);
            run_req(tbl[i].rw, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, rd, er, lat);
            check($sformatf("vec%0d_lat", i), lat, LAT);
            check($sformatf("vec%0d_rdata", i), rd & tbl[i].mask, tbl[i].exp_rdata);
            check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, tbl[i].exp_err});
        end

        // Back-to-back: req_valid held high across two requests.
        @(negedge clk);
        req_valid = 1'b1; req_rw = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_addr = 32'h10;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk); #1;
            if (e == 5) req_valid = 1'b0;
            check($sformatf("b2b_ready_e%0d", e), {31'd0, req_ready}, (e == 4 || e == 9) ? 32'd1 : 32'd0);
            check($sformatf("b2b_valid_e%0d", e), {31'd0, rsp_valid}, (e == 3 || e == 8) ? 32'd1 : 32'd0);
            if (e == 3 || e == 8) check($sformatf("b2b_rdata_e%0d", e), rsp_rdata, 32'hDEADBEEF);
        end

        // Reset during WAIT aborts the write.
        do_model_req("pre40", 1'b0, 2'b00, 1'b0, 32'h40, 32'h01020304);
        do_model_req("pre_rd", 1'b1, 2'b00, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        req_valid = 1'b1; req_rw = 1'b0; req_size = 2'b00; req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        check("abort_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_rdata", rsp_rdata, 32'd0);
        check("abort_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk); reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        check("abort_no_rsp", {31'd0, seen}, 32'd0);
        run_req(1'b1, 2'b00, 1'b0, 32'h40, 32'h0, rd, er, lat);
        check("abort_contents", rd, 32'h01020304);

        // Unaligned word store.
        do_model_req("pre_u0", 1'b0, 2'b00, 1'b0, 32'h40, 32'hAABBCCDD);
        do_model_req("pre_u1", 1'b0, 2'b00, 1'b0, 32'h44, 32'h55667788);
        model_access(1'b0, 2'b00, 1'b0, 32'h41, 32'h11223344, erd, eer);
        run_req(1'b0, 2'b00, 1'b0, 32'h41, 32'h11223344, rd, er, lat);
`ifdef DATA_MEM_HS_ALIGN_CHECK_EN
        check("unaligned_err", {31'd0, er}, 32'd1);
        run_req(1'b1, 2'b00, 1'b0, 32'h40, 32'h0, rd, er, lat);
        check("unaligned_w0", rd, 32'hAABBCCDD);
        run_req(1'b1, 2'b00, 1'b0, 32'h44, 32'h0, rd, er, lat);
        check("unaligned_w1", rd, 32'h55667788);
`else
        check("unaligned_err", {31'd0, er}, 32'd0);
        run_req(1'b1, 2'b00, 1'b0, 32'h41, 32'h0, rd, er, lat);
        check("unaligned_rd", rd, 32'h11223344);
        run_req(1'b1, 2'b00, 1'b0, 32'h44, 32'h0, rd, er, lat);
        check("unaligned_w1", rd, 32'h44667788);
`endif

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 15);
            if ($urandom_range(0, 31) == 0) addr = 32'hFFFFFFF0 + $urandom_range(0, 15);
            else addr = $urandom_range(0, DEPTH + 3);
            do_model_req("rand", 1'($urandom), (r == 15) ? 2'b11 : 2'(r % 3),
                         1'($urandom), addr, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_hs.md
DATA_MEM_HS -- requirements
Module: data_mem_hs

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 256, byte capacity of the storage array (power of two, 16..65536).
REQ-002 SHALL have parameter ADDR_W, default 32, request address width.
REQ-003 SHALL have parameter LATENCY, default 1, wait cycles from acceptance to access (1..15).
REQ-004 SHALL use a single clock and a synchronous, active-high reset; all state changes on the rising edge of clk.
REQ-005 Ports, in this order:
  - clk  in  1  clock
  - reset  in  1  synchronous active-high reset
  - req_valid  in  1  request present
  - req_ready  out  1  request can be accepted
  - req_rw  in  1  1 = read, 0 = write
  - req_size  in  2  00 word, 01 byte, 10 halfword, 11 illegal
  - req_signed  in  1  sign-extend byte/halfword loads
  - req_addr  in  ADDR_W  byte address
  - req_wdata  in  32  store data, right-justified for byte/half
  - rsp_valid  out  1  one-cycle response strobe
  - rsp_rdata  out  32  load data
  - rsp_err  out  1  request rejected, no access performed

Function
REQ-006 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; req_ready = 1 only in IDLE.
REQ-007 IDLE: on req_valid=1, latch all req_* fields, load counter with LATENCY, go to WAIT; req_valid=0 stays IDLE.
REQ-008 WAIT: decrement counter each cycle; on the edge where counter reaches 0, perform access, go to RESP.
REQ-009 Request accepted at edge k: access at edge k+LATENCY; rsp_valid high for exactly the cycle after that edge; back in IDLE after edge k+LATENCY+1.
REQ-010 Accepted requests complete; rsp has no back-pressure; req_* changes after acceptance have no effect.
REQ-011 Byte order big-endian: word store mem[A]=wdata[31:24] .. mem[A+3]=wdata[7:0]; half store mem[A]=wdata[15:8], mem[A+1]=wdata[7:0]; byte store mem[A]=wdata[7:0].
REQ-012 Loads right-justified: byte in [7:0], half in [15:0]; upper bits zero when req_signed=0, copies of MSB when req_signed=1; req_signed ignored for word and writes.
REQ-013 Write response: rsp_rdata = 0, rsp_err = 0 when legal.
REQ-014 rsp_err = 1, no memory change, rsp_rdata = 0 when req_size=11 or A + nbytes - 1 >= DEPTH_BYTES (no wrap-around).
REQ-015 rsp_rdata and rsp_err SHALL hold their last values while rsp_valid = 0.

Reset
REQ-016 reset SHALL force state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, req_ready 1 on the following cycle.
REQ-017 Reset in WAIT SHALL abort the request: no write, no response; reset in RESP drops the strobe.
REQ-018 Storage array SHALL NOT be cleared by reset; reset has priority over req_valid in the same cycle.

Configuration
REQ-019 Macro DATA_MEM_HS_ALIGN_CHECK_EN defined: half at odd A or word at A%4 != 0 SHALL give rsp_err = 1, no access.
REQ-020 Macro undefined: unaligned accesses SHALL be performed at consecutive byte addresses per REQ-011, subject only to REQ-014.

Structure
REQ-021 Shared package dmem_pkg SHALL hold size encodings SZ_WORD/SZ_BYTE/SZ_HALF, FSM state type, and LATENCY_MAX = 15.
REQ-022 Load extraction/extension SHALL be a combinational sub-module dmem_lane_align (inputs: 4 raw bytes, size, signed; output: 32-bit data).
REQ-023 Parameter checks: LATENCY outside 1..15 or non-power-of-two DEPTH_BYTES SHALL be an elaboration error.

Verification
REQ-024 Word write 0xDEADBEEF @0x10, then word read @0x10 -> rdata 0xDEADBEEF; byte read @0x10 unsigned -> 0x000000DE; byte read @0x13 signed -> 0xFFFFFFEF.
REQ-025 Half read @0x12 signed after REQ-024 write -> 0xFFFFBEEF; half write 0x1234 @0x20 then word read @0x20 -> 0x1234xxxx (upper half 0x1234).
REQ-026 LATENCY=3: req accepted at edge 0 -> rsp_valid high only in cycle after edge 3; req_ready low cycles 1..4; back-to-back req_valid held -> second accepted at edge 5.
REQ-027 Word write @DEPTH_BYTES-2 -> rsp_err 1, rdata 0, bytes at DEPTH_BYTES-2/-1 unchanged; req_size=11 -> rsp_err 1.
REQ-028 Reset asserted in WAIT of word write 0xCAFEF00D @0x40 -> no rsp_valid, later read @0x40 returns prior contents.
REQ-029 Word write @0x41 with DATA_MEM_HS_ALIGN_CHECK_EN -> rsp_err 1, no change; without -> bytes 0x41..0x44 written, read @0x41 returns same word.
